md_issue: RTL and testbench

Issue-side controller for the HI/LO multiply/divide unit in the 5-stage MIPS pipeline. It decodes the D-stage instruction into a 4-bit unit opcode and registers it into the E stage. It keeps a cycle-exact mirror of the unit's busy countdown, and stalls D whenever an HI/LO instruction would reach the unit while an operation is in flight. It sits between the decode stage and the multiply/divide unit, and it drives that unit's `xaluop_d` and `xaluop_e` inputs.

---
 rtl/md_pkg.sv | 40 ++++
 rtl/md_decode.sv | 37 +++
 rtl/md_issue.sv | 86 ++++++++
 tb/tb_md_issue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide path: unit opcodes,
// R-type funct codes and default unit latencies. Both the issue controller
// and the multiply/divide unit import this so opcode values always agree.
package md_pkg;

    // 4-bit opcode carried on xaluop_d / xaluop_e
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MTLO  = 4'd1,
        MD_MTHI  = 4'd2,
        MD_DIVU  = 4'd3,
        MD_DIV   = 4'd4,
        MD_MULTU = 4'd5,
        MD_MULT  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MFHI  = 4'd8
    } md_op_e;

    // SPECIAL opcode field and the funct codes of the HI/LO instructions
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Default busy cycles of the unit after an operation enters E
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // True for opcodes that start a multi-cycle operation in the unit
    function automatic logic md_is_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational decoder: 32-bit instruction to 4-bit multiply/divide opcode.
// Only SPECIAL-class (opcode field 0) instructions can map to a nonzero value.
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  op
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    // Register/shift fields play no part in selecting the unit opcode
    assign unused_bits = ^instr[25:6];

    // Funct lookup, gated by the SPECIAL opcode field
    always_comb begin
        op = MD_NONE;
        if (opcode == OPC_SPECIAL) begin
            unique case (funct)
                FUNCT_MULT:  op = MD_MULT;
                FUNCT_MULTU: op = MD_MULTU;
                FUNCT_DIV:   op = MD_DIV;
                FUNCT_DIVU:  op = MD_DIVU;
                FUNCT_MTHI:  op = MD_MTHI;
                FUNCT_MTLO:  op = MD_MTLO;
                FUNCT_MFLO:  op = MD_MFLO;
                FUNCT_MFHI:  op = MD_MFHI;
                default:     op = MD_NONE;
            endcase
        end
    end

endmodule

// File: rtl/md_issue.sv
// Issue-side controller for the HI/LO multiply/divide unit. Decodes the
// D-stage instruction, registers the opcode into E, mirrors the unit's busy
// countdown cycle-for-cycle and stalls D on any HI/LO hazard.
module md_issue
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        stall_other,
    input  logic        flush_e,
    output logic [3:0]  xaluop_d,
    output logic [3:0]  xaluop_e,
    output logic        xstall,
    output logic [3:0]  busy_cnt,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT);

    logic [3:0]  op_d;
    logic [3:0]  xaluop_e_q, xaluop_e_d;
    logic [3:0]  busy_q,     busy_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    md_decode u_decode (
        .instr (instr_d),
        .op    (op_d)
    );

    // Hazard: any HI/LO op in D while the unit is counting, or while an
    // operation sits in E one cycle before the counter is loaded
    always_comb begin
        stall = (op_d != MD_NONE) && ((busy_q != 4'd0) || md_is_start(xaluop_e_q));
    end

    // E-stage opcode: any bubble source (flush, own stall, other stall) wins
    always_comb begin
        xaluop_e_d = op_d;
        if (flush_e || stall || stall_other) begin
            xaluop_e_d = MD_NONE;
        end
    end

    // Busy mirror: follows the unit's countdown, driven only by the E opcode
    always_comb begin
        busy_d = busy_q;
        unique case (xaluop_e_q)
            MD_MULT, MD_MULTU: busy_d = MULT_LOAD;
            MD_DIV,  MD_DIVU:  busy_d = DIV_LOAD;
            MD_MTHI, MD_MTLO:  busy_d = 4'd0;
            MD_NONE:           busy_d = (busy_q != 4'd0) ? busy_q - 4'd1 : 4'd0;
            default:           busy_d = busy_q;
        endcase
    end

    // Stall-cycle performance counter, wraps naturally at 32 bits
    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            xaluop_e_q  <= MD_NONE;
            busy_q      <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            xaluop_e_q  <= xaluop_e_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign xaluop_d     = op_d;
    assign xaluop_e     = xaluop_e_q;
    assign xstall       = stall;
    assign busy_cnt     = busy_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_md_issue.sv
// Directed self-checking bench for md_issue with default latencies.
module tb_md_issue;

    localparam logic [31:0] I_MULT  = 32'h0085_0018;
    localparam logic [31:0] I_MULTU = 32'h0085_0019;
    localparam logic [31:0] I_DIV   = 32'h0085_001A;
    localparam logic [31:0] I_DIVU  = 32'h0085_001B;
    localparam logic [31:0] I_MTHI  = 32'h0080_0011;
    localparam logic [31:0] I_MTLO  = 32'h0080_0013;
    localparam logic [31:0] I_MFLO  = 32'h0000_1012;
    localparam logic [31:0] I_MFHI  = 32'h0000_1010;
    localparam logic [31:0] I_ADDU  = 32'h0085_1021;
    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_ADDI_F18 = 32'h2000_0018; // funct bits of mult, non-SPECIAL

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d;
    logic        stall_other;
    logic        flush_e;
    logic [3:0]  xaluop_d;
    logic [3:0]  xaluop_e;
    logic        xstall;
    logic [3:0]  busy_cnt;
    logic [31:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_issue dut (
        .clk          (clk),
        .reset        (reset),
        .instr_d      (instr_d),
        .stall_other  (stall_other),
        .flush_e      (flush_e),
        .xaluop_d     (xaluop_d),
        .xaluop_e     (xaluop_e),
        .xstall       (xstall),
        .busy_cnt     (busy_cnt),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before inspecting outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dec_instr [10];
    logic [3:0]  dec_exp   [10];

    initial begin
        dec_instr = '{I_MULT, I_MULTU, I_DIV, I_DIVU, I_MTHI, I_MTLO, I_MFLO, I_MFHI, I_ADDU, I_ADDI_F18};
        dec_exp   = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0};

        // ---- Reset for two cycles with mult in D
        reset = 1'b1; instr_d = I_MULT; stall_other = 1'b0; flush_e = 1'b0;
        step(); step();
        check("rst_xaluop_e", 32'(xaluop_e), 0);
        check("rst_busy", 32'(busy_cnt), 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_xstall", 32'(xstall), 0);
        $display("[TB] reset: e=%0d busy=%0d sc=%0d", xaluop_e, busy_cnt, stall_cycles);

        // ---- Decode table (combinational), still in reset
        for (int i = 0; i < 10; i++) begin
            instr_d = dec_instr[i];
            #1;
            check($sformatf("decode_%0d", i), 32'(xaluop_d), 32'(dec_exp[i]));
            $display("[TB] decode instr=%08h op=%0d", instr_d, xaluop_d);
        end

        // ---- mult then mflo back-to-back
        instr_d = I_MULT; reset = 1'b0;
        step();
        instr_d = I_MFLO;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("mm_xstall_%0d", k), 32'(xstall), 1);
            check($sformatf("mm_busy_%0d", k), 32'(busy_cnt), (k == 0) ? 0 : 6 - k);
            check($sformatf("mm_e_%0d", k), 32'(xaluop_e), (k == 0) ? 6 : 0);
            $display("[TB] mult/mflo k=%0d e=%0d busy=%0d xstall=%0d", k, xaluop_e, busy_cnt, xstall);
            step();
        end
        check("mm_release", 32'(xstall), 0);
        check("mm_busy_end", 32'(busy_cnt), 0);
        step();
        instr_d = I_NOP;
        check("mm_mflo_in_e", 32'(xaluop_e), 7);
        check("mm_stall_cycles", stall_cycles, 6);
        $display("[TB] mult/mflo done e=%0d sc=%0d", xaluop_e, stall_cycles);
        step();

        // ---- div then addu, addu, mfhi
        instr_d = I_DIV;
        step();
        check("dv_e", 32'(xaluop_e), 4);
        instr_d = I_ADDU;
        #1;
        check("dv_addu1_xstall", 32'(xstall), 0);
        step();
        check("dv_busy10", 32'(busy_cnt), 10);
        check("dv_addu1_e", 32'(xaluop_e), 0);
        check("dv_addu2_xstall", 32'(xstall), 0);
        step();
        instr_d = I_MFHI;
        #1;
        for (int b = 9; b > 0; b--) begin
            check($sformatf("dv_busy_%0d", b), 32'(busy_cnt), b);
            check($sformatf("dv_xstall_%0d", b), 32'(xstall), 1);
            $display("[TB] div/mfhi busy=%0d xstall=%0d", busy_cnt, xstall);
            step();
        end
        check("dv_busy0", 32'(busy_cnt), 0);
        check("dv_release", 32'(xstall), 0);
        step();
        instr_d = I_NOP;
        check("dv_mfhi_in_e", 32'(xaluop_e), 8);
        check("dv_stall_cycles", stall_cycles, 15);
        $display("[TB] div/mfhi done e=%0d sc=%0d", xaluop_e, stall_cycles);
        step();

        // ---- mthi arriving while mult busy = 3
        instr_d = I_MULT;
        step();
        instr_d = I_NOP;
        step(); step(); step();
        instr_d = I_MTHI;
        #1;
        check("mh_busy3", 32'(busy_cnt), 3);
        check("mh_xstall", 32'(xstall), 1);
        step(); step();
        check("mh_busy1_xstall", 32'(xstall), 1);
        step();
        check("mh_busy0", 32'(busy_cnt), 0);
        check("mh_release", 32'(xstall), 0);
        step();
        instr_d = I_NOP;
        check("mh_e", 32'(xaluop_e), 2);
        check("mh_busy_e", 32'(busy_cnt), 0);
        step();
        check("mh_busy_after", 32'(busy_cnt), 0);
        check("mh_stall_cycles", stall_cycles, 18);
        $display("[TB] mthi done busy=%0d sc=%0d", busy_cnt, stall_cycles);

        // ---- Reset mid-operation at busy = 7 with mflo in D
        instr_d = I_DIV;
        step();
        instr_d = I_NOP;
        step(); step(); step(); step();
        instr_d = I_MFLO;
        #1;
        check("rm_busy7", 32'(busy_cnt), 7);
        check("rm_xstall_pre", 32'(xstall), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_busy0", 32'(busy_cnt), 0);
        check("rm_e0", 32'(xaluop_e), 0);
        check("rm_sc0", stall_cycles, 0);
        check("rm_xstall", 32'(xstall), 0);
        step();
        check("rm_mflo_e", 32'(xaluop_e), 7);
        check("rm_sc_still0", stall_cycles, 0);
        $display("[TB] reset-mid done e=%0d busy=%0d sc=%0d", xaluop_e, busy_cnt, stall_cycles);

        // ---- Bubble: flush_e with mult in D
        instr_d = I_MULT; flush_e = 1'b1;
        step();
        flush_e = 1'b0; instr_d = I_NOP;
        check("fl_e", 32'(xaluop_e), 0);
        step();
        check("fl_busy", 32'(busy_cnt), 0);

        // ---- Bubble: stall_other with multu in D
        instr_d = I_MULTU; stall_other = 1'b1;
        step();
        stall_other = 1'b0; instr_d = I_NOP;
        check("so_e", 32'(xaluop_e), 0);
        check("so_sc", stall_cycles, 0);
        step();
        check("so_busy", 32'(busy_cnt), 0);

        // ---- flush_e coinciding with xstall gives one bubble
        instr_d = I_MULT;
        step();
        instr_d = I_MFLO; flush_e = 1'b1;
        step();
        flush_e = 1'b0;
        check("fx_e", 32'(xaluop_e), 0);
        check("fx_busy", 32'(busy_cnt), 5);
        check("fx_sc", stall_cycles, 1);
        // stall_other during the countdown leaves busy untouched
        stall_other = 1'b1;
        step();
        stall_other = 1'b0;
        check("fx_so_busy", 32'(busy_cnt), 4);
        $display("[TB] bubbles done busy=%0d sc=%0d", busy_cnt, stall_cycles);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
